// File: rtl/acc_icb_loader.sv
// acc_icb_loader: ICB master that copies a block of words from system memory into the
// accelerator's SRAM window, one transaction at a time, then optionally kicks its CTRL register.
module acc_icb_loader #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            LEN_W     = 16,
  parameter logic [AW-1:0] CTRL_ADDR = AW'(32'h1010_0004)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    src_addr,
  input  logic [AW-1:0]    dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             kick_en,
  input  logic [DW-1:0]    kick_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             m_icb_cmd_valid,
  input  logic             m_icb_cmd_ready,
  output logic [AW-1:0]    m_icb_cmd_addr,
  output logic             m_icb_cmd_read,
  output logic [DW-1:0]    m_icb_cmd_wdata,
  output logic [DW/8-1:0]  m_icb_cmd_wmask,
  input  logic             m_icb_rsp_valid,
  output logic             m_icb_rsp_ready,
  input  logic             m_icb_rsp_err,
  input  logic [DW-1:0]    m_icb_rsp_rdata
);

  localparam int MW = DW / 8;

  typedef enum logic [2:0] {
    IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP, KICK_CMD, KICK_RSP, FIN
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic [DW-1:0]    data_q, data_d, kick_data_q, kick_data_d;
  logic             kick_en_q, kick_en_d;
  logic             err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic             cmd_valid_q, cmd_valid_d, cmd_read_q, cmd_read_d;
  logic [AW-1:0]    cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]    cmd_wdata_q, cmd_wdata_d;
  logic [MW-1:0]    cmd_wmask_q, cmd_wmask_d;

  assign cnt_dec = cnt_q - LEN_W'(1);

  // Next-state logic; command outputs are decoded from the next state so they come out of flops.
  // A start coinciding with the done pulse is blocked by the done_q term.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    kick_en_d   = kick_en_q;
    kick_data_d = kick_data_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = (state_q == FIN);

    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          src_d       = src_addr;
          dst_d       = dst_addr;
          cnt_d       = len_words;
          kick_en_d   = kick_en;
          kick_data_d = kick_data;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          if (len_words != '0)  state_d = RD_CMD;
          else if (kick_en)     state_d = KICK_CMD;
          else                  state_d = FIN;
        end
      end
      RD_CMD: if (m_icb_cmd_ready) state_d = RD_RSP;
      RD_RSP: begin
        if (m_icb_rsp_valid) begin
          data_d = m_icb_rsp_rdata;
          if (m_icb_rsp_err) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = WR_CMD;
          end
        end
      end
      WR_CMD: if (m_icb_cmd_ready) state_d = WR_RSP;
      WR_RSP: begin
        if (m_icb_rsp_valid) begin
          if (m_icb_rsp_err) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            src_d = src_q + AW'(4);
            dst_d = dst_q + AW'(4);
            cnt_d = cnt_dec;
            if (cnt_dec != '0)   state_d = RD_CMD;
            else if (kick_en_q)  state_d = KICK_CMD;
            else                 state_d = FIN;
          end
        end
      end
      KICK_CMD: if (m_icb_cmd_ready) state_d = KICK_RSP;
      KICK_RSP: begin
        if (m_icb_rsp_valid) begin
          if (m_icb_rsp_err) err_d = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_valid_d = 1'b0;
    cmd_read_d  = cmd_read_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_wmask_d = '0;
    case (state_d)
      RD_CMD: begin
        cmd_valid_d = 1'b1;
        cmd_read_d  = 1'b1;
        cmd_addr_d  = src_d;
        cmd_wmask_d = '1;
      end
      WR_CMD: begin
        cmd_valid_d = 1'b1;
        cmd_read_d  = 1'b0;
        cmd_addr_d  = dst_d;
        cmd_wdata_d = data_d;
        cmd_wmask_d = '1;
      end
      KICK_CMD: begin
        cmd_valid_d = 1'b1;
        cmd_read_d  = 1'b0;
        cmd_addr_d  = CTRL_ADDR;
        cmd_wdata_d = kick_data_d;
        cmd_wmask_d = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      kick_en_q   <= 1'b0;
      kick_data_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      kick_en_q   <= kick_en_d;
      kick_data_q <= kick_data_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_read_q  <= cmd_read_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wmask_q <= cmd_wmask_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign m_icb_cmd_valid = cmd_valid_q;
  assign m_icb_cmd_read  = cmd_read_q;
  assign m_icb_cmd_addr  = cmd_addr_q;
  assign m_icb_cmd_wdata = cmd_wdata_q;
  assign m_icb_cmd_wmask = cmd_wmask_q;
  assign m_icb_rsp_ready = (state_q == RD_RSP) || (state_q == WR_RSP) || (state_q == KICK_RSP);

endmodule

// File: tb/tb_acc_icb_loader.sv
// tb_acc_icb_loader: drives copy jobs into acc_icb_loader through a modelled ICB slave and checks
// the issued command stream, err flag and start-to-done latency against a job-level model.
module tb_acc_icb_loader;

  localparam logic [31:0] CTRL = 32'h1010_0004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len_words;
  logic        kick_en;
  logic [31:0] kick_data;
  logic        busy, done, err;
  logic        m_icb_cmd_valid, m_icb_cmd_ready, m_icb_cmd_read;
  logic [31:0] m_icb_cmd_addr, m_icb_cmd_wdata;
  logic [3:0]  m_icb_cmd_wmask;
  logic        m_icb_rsp_valid, m_icb_rsp_ready, m_icb_rsp_err;
  logic [31:0] m_icb_rsp_rdata;

  always #5 clk = ~clk;

  acc_icb_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .kick_en(kick_en), .kick_data(kick_data),
    .busy(busy), .done(done), .err(err),
    .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
    .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
    .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
    .m_icb_rsp_err(m_icb_rsp_err), .m_icb_rsp_rdata(m_icb_rsp_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
  } cmd_t;

  int compare_count = 0;
  int mismatch_count = 0;

  cmd_t        exp_q[$];
  int          stall_arr[64];
  int          delay_arr[64];
  int          n_exp, err_at, cmd_idx, stall_cnt, pend_wait;
  bit          pend, pend_err, prev_stalled;
  logic [31:0] pend_data, prev_addr, prev_wdata;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Source memory contents as seen by the slave
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic reset_slave();
    exp_q.delete();
    n_exp = 0; err_at = -1; cmd_idx = 0; stall_cnt = 0; pend_wait = 0;
    pend = 0; pend_err = 0; prev_stalled = 0;
    m_icb_cmd_ready = 0; m_icb_rsp_valid = 0; m_icb_rsp_err = 0; m_icb_rsp_rdata = 0;
  endtask

  // Called once per negedge: check held commands, drive slave inputs, account for the next edge
  task automatic slave_step();
    int st;
    cmd_t e;
    if (prev_stalled) begin
      checkOutput("hold_valid", m_icb_cmd_valid, 1'b1);
      checkOutput("hold_addr", m_icb_cmd_addr, prev_addr);
      checkOutput("hold_wdata", m_icb_cmd_wdata, prev_wdata);
    end
    m_icb_rsp_valid = 0; m_icb_rsp_err = 0; m_icb_rsp_rdata = $urandom;
    if (pend) begin
      if (pend_wait > 0) pend_wait--;
      else begin
        m_icb_rsp_valid = 1; m_icb_rsp_err = pend_err; m_icb_rsp_rdata = pend_data;
      end
    end
    st = (cmd_idx < 64) ? stall_arr[cmd_idx] : 0;
    m_icb_cmd_ready = 0;
    if (m_icb_cmd_valid && !pend) begin
      if (stall_cnt < st) stall_cnt++;
      else m_icb_cmd_ready = 1;
    end
    if (m_icb_rsp_valid && m_icb_rsp_ready) pend = 0;
    prev_stalled = m_icb_cmd_valid && !m_icb_cmd_ready;
    prev_addr = m_icb_cmd_addr;
    prev_wdata = m_icb_cmd_wdata;
    if (m_icb_cmd_valid && m_icb_cmd_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("cmd_extra", cmd_idx + 1, n_exp);
      end else begin
        e = exp_q.pop_front();
        checkOutput("cmd_addr", m_icb_cmd_addr, e.addr);
        checkOutput("cmd_read", m_icb_cmd_read, e.read);
        checkOutput("cmd_wmask", m_icb_cmd_wmask, 4'hF);
        if (!e.read) checkOutput("cmd_wdata", m_icb_cmd_wdata, e.wdata);
      end
      pend = 1;
      pend_err = (cmd_idx == err_at);
      pend_data = m_icb_cmd_read ? mem_word(m_icb_cmd_addr) : $urandom;
      pend_wait = (cmd_idx < 64) ? delay_arr[cmd_idx] : 0;
      cmd_idx++;
      stall_cnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
  endtask

  // Builds the expected command list for a job, returns the expected start-to-done latency
  task automatic build_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input bit kick, input logic [31:0] kdata, input int err_idx,
                           input int stall_min, input int stall_max, input int delay_max,
                           output int exp_cycles, output bit exp_err);
    reset_slave();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{src + 32'(4 * i), 1'b1, 32'h0});
      exp_q.push_back('{dst + 32'(4 * i), 1'b0, mem_word(src + 32'(4 * i))});
    end
    if (kick) exp_q.push_back('{CTRL, 1'b0, kdata});
    exp_err = 0;
    if (err_idx >= 0 && err_idx < exp_q.size()) begin
      while (exp_q.size() > err_idx + 1) void'(exp_q.pop_back());
      err_at = err_idx;
      exp_err = 1;
    end
    n_exp = exp_q.size();
    exp_cycles = 2;
    for (int i = 0; i < 64; i++) begin
      stall_arr[i] = $urandom_range(stall_max, stall_min);
      delay_arr[i] = $urandom_range(delay_max, 0);
      if (i < n_exp) exp_cycles += 2 + stall_arr[i] + delay_arr[i];
    end
  endtask

  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int len,
                               input bit kick, input logic [31:0] kdata, input int err_idx,
                               input int stall_min, input int stall_max, input int delay_max,
                               input int restart_at, input bit start_on_done);
    int  exp_cycles, cyc;
    bit  exp_err, got_done;
    build_job(src, dst, len, kick, kdata, err_idx, stall_min, stall_max, delay_max, exp_cycles, exp_err);
    tick();
    start = 1; src_addr = src; dst_addr = dst; len_words = 16'(len); kick_en = kick; kick_data = kdata;
    cyc = 0; got_done = 0;
    while (!got_done && cyc < exp_cycles + 40) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        start = 0;
        src_addr = $urandom; dst_addr = $urandom; len_words = 16'($urandom); kick_data = $urandom;
        checkOutput("busy_after_start", busy, 1'b1);
        checkOutput("err_cleared", err, 1'b0);
      end
      if (restart_at > 0 && cyc == restart_at) begin
        start = 1; src_addr = src ^ 32'h0100_0000; len_words = 16'(len + 1);
      end
      if (restart_at > 0 && cyc == restart_at + 1) start = 0;
      if (done) got_done = 1;
    end
    checkOutput("done_seen", got_done, 1'b1);
    if (!got_done) begin
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      reset_slave();
      return;
    end
    checkOutput("latency", cyc, exp_cycles);
    checkOutput("err_flag", err, exp_err);
    checkOutput("busy_at_done", busy, 1'b0);
    if (start_on_done) begin
      start = 1; src_addr = src; dst_addr = dst; len_words = 16'd1; kick_en = 1;
    end
    tick();
    start = 0;
    checkOutput("done_pulse_end", done, 1'b0);
    checkOutput("busy_idle", busy, 1'b0);
    checkOutput("cmd_valid_idle", m_icb_cmd_valid, 1'b0);
    checkOutput("err_sticky", err, exp_err);
    checkOutput("cmds_left", exp_q.size(), 0);
  endtask

  // Reset asserted while the write of word 2 is waiting for cmd_ready
  task automatic abort_job();
    int  exp_cycles, cyc;
    bit  exp_err, found;
    logic [31:0] dst;
    dst = 32'h1018_0000;
    build_job(32'h8000_1000, dst, 4, 1'b1, 32'h1, -1, 2, 2, 0, exp_cycles, exp_err);
    tick();
    start = 1; src_addr = 32'h8000_1000; dst_addr = dst; len_words = 16'd4; kick_en = 1; kick_data = 32'h1;
    cyc = 0; found = 0;
    while (!found && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 0;
      if (m_icb_cmd_valid && !m_icb_cmd_read && m_icb_cmd_addr == dst + 32'h8) found = 1;
      else slave_step();
    end
    checkOutput("abort_reach", found, 1'b1);
    rst_n = 0;
    #1;
    checkOutput("abort_cmd_valid", m_icb_cmd_valid, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_rsp_ready", m_icb_rsp_ready, 1'b0);
    reset_slave();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort_no_done", done, 1'b0);
    end
  endtask

  initial begin
    int  len, err_idx;
    bit  kick;
    logic [31:0] src, dst;
    rst_n = 0; start = 0; src_addr = 0; dst_addr = 0; len_words = 0; kick_en = 0; kick_data = 0;
    reset_slave();
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_cmd_valid", m_icb_cmd_valid, 1'b0);
    checkOutput("rst_cmd_addr", m_icb_cmd_addr, 32'h0);
    checkOutput("rst_cmd_wmask", m_icb_cmd_wmask, 4'h0);
    checkOutput("rst_rsp_ready", m_icb_rsp_ready, 1'b0);
    rst_n = 1;

    $display("[TB] zero-wait copy of 4 words with kick");
    applyStimulus(32'h8000_0000, 32'h1014_0000, 4, 1'b1, 32'h1, -1, 0, 0, 0, 0, 1'b0);
    $display("[TB] same copy with 3-cycle command stalls");
    applyStimulus(32'h8000_0000, 32'h1014_0000, 4, 1'b1, 32'h1, -1, 3, 3, 0, 0, 1'b0);
    $display("[TB] empty job");
    applyStimulus(32'h8000_0000, 32'h1014_0000, 0, 1'b0, 32'h1, -1, 0, 0, 0, 0, 1'b0);
    $display("[TB] read error on word 1, start during done");
    applyStimulus(32'h8000_0040, 32'h1018_0000, 3, 1'b1, 32'h1, 2, 0, 0, 0, 0, 1'b1);
    applyStimulus(32'h8000_0080, 32'h1018_0100, 2, 1'b0, 32'h0, -1, 0, 0, 0, 0, 1'b0);
    $display("[TB] restart while busy");
    applyStimulus(32'h8000_0200, 32'h1014_0200, 3, 1'b1, 32'h5, -1, 0, 1, 1, 5, 1'b0);
    $display("[TB] reset mid-job");
    abort_job();
    applyStimulus(32'h8000_0300, 32'h1014_0300, 2, 1'b1, 32'h3, -1, 0, 0, 0, 0, 1'b0);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 12; j++) begin
      src = $urandom & 32'hFFFF_FFFC;
      dst = (j % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      len = $urandom_range(6, 0);
      kick = 1'($urandom);
      err_idx = ($urandom_range(2, 0) == 0) ? int'($urandom_range(2 * len + 1, 0)) : -1;
      applyStimulus(src, dst, len, kick, $urandom, err_idx, 0, $urandom_range(3, 0),
                    $urandom_range(2, 0), 0, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
